// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS tuning word through a start->stop ramp.
// Latency: first point one cycle after start is sampled; each point is held dwell+1 cycles.
// Backpressure: none; start is ignored while busy or in the done cycle, abort always wins.
//
// Ports:
//   clk, rst_n                     DAC-domain clock, asynchronous active-low reset
//   start, abort                   sweep request / immediate stop, sampled every cycle
//   mode                           0 single, 1 sawtooth repeat, 2 triangle, 3 as single
//   f_start, f_stop, f_inc, dwell  sweep configuration, latched on an accepted start
//   step, step_strobe              tuning word to the DDS and its new-value pulse
//   busy, done, dir                sweep status, completion pulse, current leg (1 = down)
module dds_sweep_ctrl #(
    parameter int STEP_W  = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [STEP_W-1:0]  f_start,
    input  logic [STEP_W-1:0]  f_stop,
    input  logic [STEP_W-1:0]  f_inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic [STEP_W-1:0]  step,
    output logic               step_strobe,
    output logic               busy,
    output logic               done,
    output logic               dir
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 strobe_q, strobe_d;
    logic                 dir_q, dir_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [STEP_W-1:0]    fs_q, fs_d;
    logic [STEP_W-1:0]    fp_q, fp_d;
    logic [STEP_W-1:0]    inc_q, inc_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;

    // Ramp arithmetic is done one bit wider so neither direction can wrap.
    logic [STEP_W:0]      up_sum;
    logic [STEP_W:0]      dn_floor;
    logic [STEP_W-1:0]    up_nxt;
    logic [STEP_W-1:0]    dn_nxt;
    logic                 degen;

    always_comb begin
        up_sum   = {1'b0, step_q} + {1'b0, inc_q};
        up_nxt   = (up_sum > {1'b0, fp_q}) ? fp_q : up_sum[STEP_W-1:0];
        // cur - inc < start  <=>  cur < start + inc, evaluated without underflow
        dn_floor = {1'b0, fs_q} + {1'b0, inc_q};
        dn_nxt   = ({1'b0, step_q} < dn_floor) ? fs_q : (step_q - inc_q);
        // A zero increment or an empty/inverted range collapses to the single point f_start.
        degen    = (inc_q == '0) || (fp_q <= fs_q);
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        strobe_d = 1'b0;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        fs_d     = fs_q;
        fp_d     = fp_q;
        inc_d    = inc_q;
        dwell_d  = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = (mode == 2'd3) ? MODE_SINGLE : mode;
                    fs_d     = f_start;
                    fp_d     = f_stop;
                    inc_d    = f_inc;
                    dwell_d  = dwell;
                    step_d   = f_start;
                    strobe_d = 1'b1;
                    dir_d    = 1'b0;
                    cnt_d    = dwell;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (degen) begin
                        if (mode_q == MODE_SINGLE) begin
                            state_d = ST_DONE;
                        end else begin
                            step_d   = fs_q;
                            strobe_d = 1'b1;
                        end
                    end else if (!dir_q) begin
                        if (step_q != fp_q) begin
                            step_d   = up_nxt;
                            strobe_d = 1'b1;
                        end else if (mode_q == MODE_SAW) begin
                            step_d   = fs_q;
                            strobe_d = 1'b1;
                        end else if (mode_q == MODE_TRI) begin
                            dir_d    = 1'b1;
                            step_d   = dn_nxt;
                            strobe_d = 1'b1;
                        end else begin
                            // single sweep finished; step keeps f_stop through DONE
                            state_d = ST_DONE;
                        end
                    end else begin
                        if (step_q != fs_q) begin
                            step_d   = dn_nxt;
                            strobe_d = 1'b1;
                        end else begin
                            dir_d    = 1'b0;
                            step_d   = up_nxt;
                            strobe_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            step_d   = '0;
            strobe_d = 1'b0;
            dir_d    = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            strobe_q <= 1'b0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 2'd0;
            fs_q     <= '0;
            fp_q     <= '0;
            inc_q    <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            strobe_q <= strobe_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            fs_q     <= fs_d;
            fp_q     <= fp_d;
            inc_q    <= inc_d;
            dwell_q  <= dwell_d;
        end
    end

    assign step        = step_q;
    assign step_strobe = strobe_q;
    assign dir         = dir_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed step/strobe/status sequences per scenario.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Each scenario task compares inline and bumps the shared check/error counters.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  f_start;
    logic [7:0]  f_stop;
    logic [7:0]  f_inc;
    logic [15:0] dwell;
    logic [7:0]  step;
    logic        step_strobe;
    logic        busy;
    logic        done;
    logic        dir;

    int checks;
    int errors;

    dds_sweep_ctrl #(.STEP_W(8), .DWELL_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_inc       (f_inc),
        .dwell       (dwell),
        .step        (step),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done),
        .dir         (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [7:0] fs, input logic [7:0] fp,
                       input logic [7:0] fi, input logic [15:0] dw);
        mode = m; f_start = fs; f_stop = fp; f_inc = fi; dwell = dw;
    endtask

    // One-cycle start pulse; returns sampling the first point (o0).
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({step, step_strobe, busy, done, dir} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got step=%0d strb=%0b busy=%0b done=%0b dir=%0b, want all 0",
                     step, step_strobe, busy, done, dir);
        end
    endtask

    task automatic test_single();
        int strobes;
        logic [7:0] es;
        strobes = 0;
        cfg(2'd0, 8'd10, 8'd40, 8'd10, 16'd3);
        kick();
        for (int k = 0; k < 16; k++) begin
            es = 8'd10 + 8'(10 * (k / 4));
            if (step_strobe) strobes++;
            checks++;
            if (step !== es || step_strobe !== (k % 4 == 0) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single_seq k=%0d: got step=%0d strb=%0b busy=%0b done=%0b, want step=%0d strb=%0b busy=1 done=0",
                         k, step, step_strobe, busy, done, es, (k % 4 == 0));
            end
            // start while busy must not disturb the sweep
            start = (k == 6);
            f_start = (k == 6) ? 8'd99 : 8'd10;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || step !== 8'd40) begin
            errors++;
            $display("FAIL single_done: got done=%0b busy=%0b step=%0d, want done=1 busy=0 step=40", done, busy, step);
        end
        checks++;
        if (strobes !== 4) begin
            errors++;
            $display("FAIL single_strobes: got %0d, want 4", strobes);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || step !== 8'd40) begin
            errors++;
            $display("FAIL single_idle: got done=%0b busy=%0b step=%0d, want done=0 busy=0 step=40", done, busy, step);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] es [4];
        es[0] = 8'd10; es[1] = 8'd20; es[2] = 8'd30; es[3] = 8'd35;
        cfg(2'd3, 8'd10, 8'd35, 8'd10, 16'd0);
        kick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (step !== es[k] || step_strobe !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL clamp_seq k=%0d: got step=%0d strb=%0b done=%0b, want step=%0d strb=1 done=0",
                         k, step, step_strobe, done, es[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || step !== 8'd35) begin
            errors++;
            $display("FAIL clamp_done: got done=%0b step=%0d, want done=1 step=35", done, step);
        end
        tick();
    endtask

    task automatic test_no_wrap();
        cfg(2'd0, 8'd200, 8'd255, 8'd100, 16'd0);
        kick();
        checks++;
        if (step !== 8'd200) begin
            errors++;
            $display("FAIL nowrap_p0: got step=%0d, want 200", step);
        end
        tick();
        checks++;
        if (step !== 8'd255 || step_strobe !== 1'b1) begin
            errors++;
            $display("FAIL nowrap_p1: got step=%0d strb=%0b, want step=255 strb=1", step, step_strobe);
        end
        tick();
        checks++;
        if (done !== 1'b1 || step !== 8'd255) begin
            errors++;
            $display("FAIL nowrap_done: got done=%0b step=%0d, want done=1 step=255", done, step);
        end
        tick();
    endtask

    task automatic test_start_abort_idle();
        // step holds 255 from the previous sweep; abort must win over start
        start = 1'b1;
        abort = 1'b1;
        cfg(2'd0, 8'd50, 8'd60, 8'd1, 16'd0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || step !== 8'd0 || step_strobe !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%0b step=%0d strb=%0b, want busy=0 step=0 strb=0",
                     busy, step, step_strobe);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || step !== 8'd0) begin
            errors++;
            $display("FAIL start_abort_idle2: got busy=%0b step=%0d, want busy=0 step=0", busy, step);
        end
    endtask

    task automatic test_triangle();
        logic [7:0] es [8];
        logic       ed [8];
        es[0] = 8'd0;  es[1] = 8'd10; es[2] = 8'd20; es[3] = 8'd10;
        es[4] = 8'd0;  es[5] = 8'd10; es[6] = 8'd20; es[7] = 8'd10;
        ed[0] = 1'b0;  ed[1] = 1'b0;  ed[2] = 1'b0;  ed[3] = 1'b1;
        ed[4] = 1'b1;  ed[5] = 1'b0;  ed[6] = 1'b0;  ed[7] = 1'b1;
        cfg(2'd2, 8'd0, 8'd20, 8'd10, 16'd0);
        kick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (step !== es[k] || dir !== ed[k] || step_strobe !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL tri_seq k=%0d: got step=%0d dir=%0b strb=%0b busy=%0b done=%0b, want step=%0d dir=%0b strb=1 busy=1 done=0",
                         k, step, dir, step_strobe, busy, done, es[k], ed[k]);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (step !== 8'd0 || busy !== 1'b0 || dir !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL tri_abort: got step=%0d busy=%0b dir=%0b done=%0b, want 0 0 0 0", step, busy, dir, done);
        end
    endtask

    task automatic test_sawtooth_abort();
        logic [7:0] es [7];
        es[0] = 8'd5;  es[1] = 8'd5;  es[2] = 8'd10; es[3] = 8'd10;
        es[4] = 8'd15; es[5] = 8'd15; es[6] = 8'd5;
        cfg(2'd1, 8'd5, 8'd15, 8'd5, 16'd1);
        kick();
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (step !== es[k] || step_strobe !== (k % 2 == 0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL saw_seq k=%0d: got step=%0d strb=%0b busy=%0b, want step=%0d strb=%0b busy=1",
                         k, step, step_strobe, busy, es[k], (k % 2 == 0));
            end
            // start with a different config while busy: must be ignored
            start = (k == 2);
            mode  = (k == 2) ? 2'd0 : 2'd1;
            f_start = (k == 2) ? 8'd77 : 8'd5;
            // abort in the first cycle of the repeated 5 (counter still non-zero)
            abort = (k == 6);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (step !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0) begin
            errors++;
            $display("FAIL saw_abort: got step=%0d busy=%0b done=%0b strb=%0b, want 0 0 0 0",
                     step, busy, done, step_strobe);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL saw_post_abort k=%0d: got busy=%0b done=%0b, want 0 0", k, busy, done);
            end
        end
    endtask

    task automatic test_degenerate();
        cfg(2'd1, 8'd7, 8'd50, 8'd0, 16'd2);
        kick();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (step !== 8'd7 || step_strobe !== (k % 3 == 0) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL degen_saw k=%0d: got step=%0d strb=%0b busy=%0b done=%0b, want step=7 strb=%0b busy=1 done=0",
                         k, step, step_strobe, busy, done, (k % 3 == 0));
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        // inverted range, single mode: one point for dwell+1 cycles then done
        cfg(2'd0, 8'd30, 8'd20, 8'd5, 16'd1);
        kick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (step !== 8'd30 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL degen_single k=%0d: got step=%0d busy=%0b done=%0b, want step=30 busy=1 done=0",
                         k, step, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL degen_single_done: got done=%0b busy=%0b, want done=1 busy=0", done, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cfg(2'd2, 8'd0, 8'd20, 8'd10, 16'd0);
        kick();
        tick();
        tick();
        tick();
        // now on the down leg at step=10, dir=1
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({step, step_strobe, busy, done, dir} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got step=%0d strb=%0b busy=%0b done=%0b dir=%0b, want all 0",
                     step, step_strobe, busy, done, dir);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || step !== 8'd0 || step_strobe !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d: got busy=%0b step=%0d strb=%0b, want 0 0 0", k, busy, step, step_strobe);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        mode    = 2'd0;
        f_start = 8'd0;
        f_stop  = 8'd0;
        f_inc   = 8'd0;
        dwell   = 16'd0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single();
        test_clamp();
        test_no_wrap();
        test_start_abort_idle();
        test_triangle();
        test_sawtooth_abort();
        test_degenerate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
